// File: rtl/dsi_lp_rx_lane.sv
`default_nettype none
// ============================================================================
// Module      : dsi_lp_rx_lane
// Description : DSI data lane 0 LP receiver. It detects escape entry, decodes the
//               LPDT bytes and packs them into 32-bit words. The optional ULPS
//               handling is enabled by defining the macro DSI_RX_ULPS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dsi_lp_rx_lane #(
    parameter int FILTER_LEN     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        rx_enable,
    input  logic        LP_p_input,
    input  logic        LP_n_input,
    output logic [31:0] iface_read_data,
    output logic [3:0]  iface_read_strb,
    output logic        iface_read_valid,
    output logic        iface_read_last,
    output logic        rx_active,
    output logic        ulps_active,
    output logic        err_esc_cmd,
    output logic        err_frame,
    output logic        err_timeout
);

    localparam logic [1:0]  c_LP11     = 2'b11;
    localparam logic [1:0]  c_LP10     = 2'b10;
    localparam logic [1:0]  c_LP01     = 2'b01;
    localparam logic [1:0]  c_LP00     = 2'b00;
    localparam logic [7:0]  c_FLT_LEN  = 8'(FILTER_LEN);
    localparam logic [15:0] c_TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  c_CMD_LPDT = 8'hE1;

    localparam logic [3:0] c_ST_IDLE  = 4'd0;
    localparam logic [3:0] c_ST_STOP  = 4'd1;
    localparam logic [3:0] c_ST_LP10  = 4'd2;
    localparam logic [3:0] c_ST_ESC00 = 4'd3;
    localparam logic [3:0] c_ST_ESC01 = 4'd4;
    localparam logic [3:0] c_ST_CMD   = 4'd5;
    localparam logic [3:0] c_ST_DATA  = 4'd6;
    localparam logic [3:0] c_ST_ERR   = 4'd7;
`ifdef DSI_RX_ULPS_EN
    localparam logic [7:0] c_CMD_ULPS = 8'h1E;
    localparam logic [3:0] c_ST_ULPS  = 4'd8;
    localparam logic [3:0] c_ST_WAKE  = 4'd9;
`endif

    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  r_cand;
    logic [7:0]  r_flt_cnt;
    logic [1:0]  r_line;
    logic [1:0]  r_line_q;
    logic [3:0]  r_state;
    logic [15:0] r_to_cnt;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  r_nbytes;
    logic [31:0] r_word;

    logic        w_chg;
    logic        w_bit;
    logic        w_mark_ret;
    logic        w_byte_done;
    logic [7:0]  w_cmd_byte;
    logic [7:0]  w_data_byte;
    logic [3:0]  w_strb;
    logic        w_to_run;
    logic        w_to_hit;

    // Two-flop synchronizer; the idle line level is LP-11.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= c_LP11;
            r_sync2 <= c_LP11;
        end else begin
            r_sync1 <= {LP_p_input, LP_n_input};
            r_sync2 <= r_sync1;
        end
    end

    // A new line state needs FILTER_LEN equal consecutive samples to be accepted.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_line    <= c_LP11;
            r_cand    <= c_LP11;
            r_flt_cnt <= 8'd0;
        end else if (r_sync2 == r_line) begin
            r_cand    <= r_line;
            r_flt_cnt <= 8'd0;
        end else if (r_sync2 != r_cand) begin
            r_cand    <= r_sync2;
            r_flt_cnt <= 8'd1;
            if (c_FLT_LEN <= 8'd1) begin
                r_line <= r_sync2;
            end
        end else if ((r_flt_cnt + 8'd1) >= c_FLT_LEN) begin
            r_line    <= r_sync2;
            r_flt_cnt <= 8'd0;
        end else begin
            r_flt_cnt <= r_flt_cnt + 8'd1;
        end
    end

    assign w_chg       = (r_line != r_line_q);
    assign w_bit       = r_line_q[1];
    assign w_mark_ret  = w_chg && (r_line == c_LP00) &&
                         ((r_line_q == c_LP10) || (r_line_q == c_LP01));
    assign w_byte_done = (r_bit_cnt == 3'd7);
    assign w_cmd_byte  = {r_shift[6:0], w_bit};
    assign w_data_byte = {w_bit, r_shift[7:1]};
    assign w_strb      = 4'((5'd1 << r_nbytes) - 5'd1);

    always_comb begin
        w_to_run = 1'b1;
        case (r_state)
            c_ST_IDLE, c_ST_STOP, c_ST_ERR: w_to_run = 1'b0;
`ifdef DSI_RX_ULPS_EN
            c_ST_ULPS:                      w_to_run = 1'b0;
`endif
            default:                        w_to_run = 1'b1;
        endcase
    end

    assign w_to_hit  = w_to_run && !w_chg && (r_to_cnt == c_TO_LAST);

    assign rx_active = (r_state == c_ST_LP10)  || (r_state == c_ST_ESC00) ||
                       (r_state == c_ST_ESC01) || (r_state == c_ST_CMD)   ||
                       (r_state == c_ST_DATA);

`ifdef DSI_RX_ULPS_EN
    assign ulps_active = (r_state == c_ST_ULPS) || (r_state == c_ST_WAKE);
`else
    assign ulps_active = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_ST_IDLE;
            r_line_q         <= c_LP11;
            r_to_cnt         <= 16'd0;
            r_shift          <= 8'd0;
            r_bit_cnt        <= 3'd0;
            r_nbytes         <= 3'd0;
            r_word           <= 32'd0;
            iface_read_data  <= 32'd0;
            iface_read_strb  <= 4'd0;
            iface_read_valid <= 1'b0;
            iface_read_last  <= 1'b0;
            err_esc_cmd      <= 1'b0;
            err_frame        <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            r_line_q         <= r_line;
            iface_read_data  <= 32'd0;
            iface_read_strb  <= 4'd0;
            iface_read_valid <= 1'b0;
            iface_read_last  <= 1'b0;
            err_esc_cmd      <= 1'b0;
            err_frame        <= 1'b0;
            err_timeout      <= 1'b0;

            if (w_chg || !w_to_run) begin
                r_to_cnt <= 16'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end

            if (!rx_enable) begin
                r_state   <= c_ST_IDLE;
                r_shift   <= 8'd0;
                r_bit_cnt <= 3'd0;
                r_nbytes  <= 3'd0;
                r_word    <= 32'd0;
            end else if (w_to_hit) begin
                err_timeout <= 1'b1;
                r_state     <= c_ST_ERR;
                r_shift     <= 8'd0;
                r_bit_cnt   <= 3'd0;
                r_nbytes    <= 3'd0;
                r_word      <= 32'd0;
            end else begin
                case (r_state)
                    c_ST_IDLE: r_state <= c_ST_STOP;

                    c_ST_STOP: begin
                        if (w_chg && (r_line == c_LP10) && (r_line_q == c_LP11)) begin
                            r_state <= c_ST_LP10;
                        end
                    end

                    c_ST_LP10: begin
                        if (w_chg) begin
                            if (r_line == c_LP00)      r_state <= c_ST_ESC00;
                            else if (r_line == c_LP11) r_state <= c_ST_STOP;
                            else                       r_state <= c_ST_ERR;
                        end
                    end

                    c_ST_ESC00: begin
                        if (w_chg) begin
                            if (r_line == c_LP01)      r_state <= c_ST_ESC01;
                            else if (r_line == c_LP11) r_state <= c_ST_STOP;
                            else                       r_state <= c_ST_ERR;
                        end
                    end

                    c_ST_ESC01: begin
                        if (w_chg) begin
                            if (r_line == c_LP00) begin
                                r_state   <= c_ST_CMD;
                                r_shift   <= 8'd0;
                                r_bit_cnt <= 3'd0;
                                r_nbytes  <= 3'd0;
                                r_word    <= 32'd0;
                            end else if (r_line == c_LP11) begin
                                r_state <= c_ST_STOP;
                            end else begin
                                r_state <= c_ST_ERR;
                            end
                        end
                    end

                    // Entry command arrives MSB first.
                    c_ST_CMD: begin
                        if (w_mark_ret) begin
                            if (w_byte_done) begin
                                r_shift   <= 8'd0;
                                r_bit_cnt <= 3'd0;
                                if (w_cmd_byte == c_CMD_LPDT) begin
                                    r_state <= c_ST_DATA;
`ifdef DSI_RX_ULPS_EN
                                end else if (w_cmd_byte == c_CMD_ULPS) begin
                                    r_state <= c_ST_ULPS;
`endif
                                end else begin
                                    err_esc_cmd <= 1'b1;
                                    r_state     <= c_ST_ERR;
                                end
                            end else begin
                                r_shift   <= w_cmd_byte;
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end else if (w_chg && (r_line == c_LP11)) begin
                            err_frame <= 1'b1;
                            r_state   <= c_ST_STOP;
                            r_shift   <= 8'd0;
                            r_bit_cnt <= 3'd0;
                        end else if (w_chg && (r_line_q != c_LP00)) begin
                            r_state   <= c_ST_ERR;
                            r_shift   <= 8'd0;
                            r_bit_cnt <= 3'd0;
                        end
                    end

                    // Payload bits arrive LSB first; a full word waits for the
                    // next byte or the exit so that 'last' can be set correctly.
                    c_ST_DATA: begin
                        if (w_mark_ret) begin
                            if (w_byte_done) begin
                                r_shift   <= 8'd0;
                                r_bit_cnt <= 3'd0;
                                if (r_nbytes == 3'd4) begin
                                    iface_read_valid <= 1'b1;
                                    iface_read_data  <= r_word;
                                    iface_read_strb  <= 4'hF;
                                    iface_read_last  <= 1'b0;
                                    r_word           <= {24'd0, w_data_byte};
                                    r_nbytes         <= 3'd1;
                                end else begin
                                    r_word[{r_nbytes[1:0], 3'b000} +: 8] <= w_data_byte;
                                    r_nbytes <= r_nbytes + 3'd1;
                                end
                            end else begin
                                r_shift   <= w_data_byte;
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end else if (w_chg && (r_line == c_LP11)) begin
                            if (r_line_q == c_LP10) begin
                                if (r_nbytes != 3'd0) begin
                                    iface_read_valid <= 1'b1;
                                    iface_read_data  <= r_word;
                                    iface_read_strb  <= w_strb;
                                    iface_read_last  <= 1'b1;
                                end
                                if (r_bit_cnt != 3'd0) begin
                                    err_frame <= 1'b1;
                                end
                            end else begin
                                err_frame <= 1'b1;
                            end
                            r_state   <= c_ST_STOP;
                            r_shift   <= 8'd0;
                            r_bit_cnt <= 3'd0;
                            r_nbytes  <= 3'd0;
                            r_word    <= 32'd0;
                        end else if (w_chg && (r_line_q != c_LP00)) begin
                            r_state   <= c_ST_ERR;
                            r_shift   <= 8'd0;
                            r_bit_cnt <= 3'd0;
                            r_nbytes  <= 3'd0;
                            r_word    <= 32'd0;
                        end
                    end

                    c_ST_ERR: begin
                        if (r_line == c_LP11) begin
                            r_state <= c_ST_STOP;
                        end
                    end

`ifdef DSI_RX_ULPS_EN
                    c_ST_ULPS: begin
                        if (w_chg) begin
                            if (r_line == c_LP10)      r_state <= c_ST_WAKE;
                            else if (r_line == c_LP11) r_state <= c_ST_STOP;
                            else                       r_state <= c_ST_ERR;
                        end
                    end

                    c_ST_WAKE: begin
                        if (w_chg) begin
                            if (r_line == c_LP11)      r_state <= c_ST_STOP;
                            else if (r_line == c_LP00) r_state <= c_ST_ULPS;
                            else                       r_state <= c_ST_ERR;
                        end
                    end
`endif

                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsi_lp_rx_lane.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for dsi_lp_rx_lane: directed LP line sequences with hand-computed words and error events.
module tb_dsi_lp_rx_lane;

    localparam int FILTER_LEN = 2;
    localparam int TIMEOUT    = 64;
    localparam int HOLD       = 4;
    localparam int K_WORD     = 0;
    localparam int K_ESC      = 1;
    localparam int K_FRAME    = 2;
    localparam int K_TO       = 3;

    typedef struct {
        int          kind;
        logic [36:0] payload;
    } ev_t;

    ev_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   to_cyc = -1;
    int   t0     = 0;
    int   lat    = 0;

    logic        clk_sys   = 1'b0;
    logic        rst_n     = 1'b0;
    logic        rx_enable = 1'b0;
    logic        lp_p      = 1'b1;
    logic        lp_n      = 1'b1;
    logic [31:0] iface_read_data;
    logic [3:0]  iface_read_strb;
    logic        iface_read_valid;
    logic        iface_read_last;
    logic        rx_active;
    logic        ulps_active;
    logic        err_esc_cmd;
    logic        err_frame;
    logic        err_timeout;

    dsi_lp_rx_lane #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_sys          (clk_sys),
        .rst_n            (rst_n),
        .rx_enable        (rx_enable),
        .LP_p_input       (lp_p),
        .LP_n_input       (lp_n),
        .iface_read_data  (iface_read_data),
        .iface_read_strb  (iface_read_strb),
        .iface_read_valid (iface_read_valid),
        .iface_read_last  (iface_read_last),
        .rx_active        (rx_active),
        .ulps_active      (ulps_active),
        .err_esc_cmd      (err_esc_cmd),
        .err_frame        (err_frame),
        .err_timeout      (err_timeout)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [36:0] p);
        ev_t e;
        e.kind    = kind;
        e.payload = p;
        sb.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] s, input logic l);
        push(K_WORD, {l, s, d});
    endtask

    task automatic pop_cmp(input int kind, input logic [36:0] p, input string name);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected event actual=%0h expected=none", name, p);
        end else begin
            e = sb.pop_front();
            check({name, "_kind"}, 64'(kind), 64'(e.kind));
            if (kind == K_WORD && e.kind == K_WORD)
                check(name, 64'(p), 64'(e.payload));
        end
    endtask

    // Output monitor: every valid or error pulse consumes one scoreboard entry.
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (iface_read_valid)
                pop_cmp(K_WORD, {iface_read_last, iface_read_strb, iface_read_data}, "word");
            if (err_esc_cmd) pop_cmp(K_ESC, 37'd0, "err_esc_cmd");
            if (err_frame)   pop_cmp(K_FRAME, 37'd0, "err_frame");
            if (err_timeout) begin
                pop_cmp(K_TO, 37'd0, "err_timeout");
                to_cyc = cyc;
            end
        end
    end

    task automatic set_line(input logic [1:0] v, input int n);
        lp_p = v[1];
        lp_n = v[0];
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bit(input logic b);
        set_line(b ? 2'b10 : 2'b01, HOLD);
        set_line(2'b00, HOLD);
    endtask

    task automatic entry();
        set_line(2'b11, HOLD);
        set_line(2'b10, HOLD);
        set_line(2'b00, HOLD);
        set_line(2'b01, HOLD);
        set_line(2'b00, HOLD);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) send_bit(c[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_bytes(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(v[i*8 +: 8]);
    endtask

    task automatic do_exit();
        set_line(2'b10, HOLD);
        set_line(2'b11, 3 * HOLD);
    endtask

    task automatic drain(input string name);
        repeat (20) @(posedge clk_sys);
        #1;
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_outputs",
              64'({iface_read_data, iface_read_strb, iface_read_valid, iface_read_last,
                   rx_active, ulps_active, err_esc_cmd, err_frame, err_timeout}), 64'd0);
        rst_n = 1'b1;
        rx_enable = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1;
        check("idle_rx_active", 64'(rx_active), 64'd0);

        // Four bytes fill exactly one word, emitted only at exit.
        push_word(32'h44332211, 4'hF, 1'b1);
        entry();
        send_cmd(8'hE1);
        send_bytes(64'h44332211, 4);
        check("rx_active_in_data", 64'(rx_active), 64'd1);
        do_exit();
        drain("t1_drain");
        check("rx_active_after_exit", 64'(rx_active), 64'd0);

        // Six bytes: full word on the fifth byte, then a two-byte tail.
        push_word(32'h04030201, 4'hF, 1'b0);
        push_word(32'h00000605, 4'h3, 1'b1);
        entry();
        send_cmd(8'hE1);
        send_bytes(64'h0000060504030201, 6);
        do_exit();
        drain("t2_drain");

        // Unsupported command, recovery through LP-11, then one byte.
        push(K_ESC, 37'd0);
        entry();
        send_cmd(8'h87);
        set_line(2'b11, 3 * HOLD);
        drain("t3a_drain");
        push_word(32'h000000A5, 4'h1, 1'b1);
        entry();
        send_cmd(8'hE1);
        send_byte(8'hA5);
        do_exit();
        drain("t3b_drain");

        // Two bytes with single-sample glitches in between, then three stray bits.
        push_word(32'h0000BBAA, 4'h3, 1'b1);
        push(K_FRAME, 37'd0);
        entry();
        send_cmd(8'hE1);
        send_byte(8'hAA);
        set_line(2'b10, 1);
        set_line(2'b00, HOLD);
        set_line(2'b01, 1);
        set_line(2'b00, HOLD);
        send_byte(8'hBB);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        do_exit();
        drain("t4_drain");

        // Line frozen at 01 mid-payload: timeout, pending byte discarded.
        push(K_TO, 37'd0);
        entry();
        send_cmd(8'hE1);
        send_byte(8'h5A);
        to_cyc = -1;
        t0 = cyc;
        set_line(2'b01, 100);
        lat = (to_cyc < 0) ? -1 : (to_cyc - t0);
        checks++;
        // 2 sync + FILTER_LEN filter + 1 FSM edge + TIMEOUT counts ~= 69 edges.
        if (lat < 67 || lat > 71) begin
            errors++;
            $display("FAIL timeout_latency actual=%0d expected=69", lat);
        end
        set_line(2'b11, 3 * HOLD);
        drain("t5_drain");

        // rx_enable dropped mid-byte: everything clears with no output.
        entry();
        send_cmd(8'hE1);
        send_byte(8'h12);
        send_bit(1'b1);
        send_bit(1'b0);
        set_line(2'b10, 2);
        rx_enable = 1'b0;
        @(posedge clk_sys);
        #1;
        check("disable_outputs",
              64'({iface_read_data, iface_read_strb, iface_read_valid, iface_read_last,
                   rx_active, ulps_active, err_esc_cmd, err_frame, err_timeout}), 64'd0);
        set_line(2'b11, 3 * HOLD);
        rx_enable = 1'b1;
        drain("t6_drain");
        check("reenable_rx_active", 64'(rx_active), 64'd0);

`ifdef DSI_RX_ULPS_EN
        entry();
        send_cmd(8'h1E);
        set_line(2'b00, 10000);
        check("ulps_active_hold", 64'(ulps_active), 64'd1);
        set_line(2'b10, HOLD);
        set_line(2'b11, 3 * HOLD);
        check("ulps_active_exit", 64'(ulps_active), 64'd0);
        drain("t7_drain");
`else
        push(K_ESC, 37'd0);
        entry();
        send_cmd(8'h1E);
        set_line(2'b11, 3 * HOLD);
        check("ulps_active_tied", 64'(ulps_active), 64'd0);
        drain("t7_drain");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
